kyber_coef_packer: RTL and testbench

//  Output-side counterpart of the signed Barrett reduction: takes the stream of reduced signed int16

---
 rtl/kyber_coef_packer_pkg.sv | 20 ++
 rtl/kyber_coef_packer_if.sv | 25 ++
 rtl/kyber_coef_packer_canon.sv | 28 ++
 rtl/kyber_coef_packer.sv | 139 +++++++++++++
 tb/tb_kyber_coef_packer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_coef_packer_pkg.sv
// Shared types and constants for the Kyber coefficient packer.
// The Barrett stage is enabled by the KYBER_COEF_PACKER_REDUCE_EN macro.
package kyber_pkg;

   localparam int KYBER_Q   = 3329;
   localparam int KYBER_N   = 256;
   localparam int BARRETT_V = 20159;

   typedef logic signed [15:0] coef_t;
   typedef logic        [11:0] ucoef_t;

   typedef enum logic [2:0] {
      ST_GET0,
      ST_GET1,
      ST_EMIT0,
      ST_EMIT1,
      ST_EMIT2
   } pack_state_e;

endpackage

// File: rtl/kyber_coef_packer_if.sv
// Coefficient-in / byte-out stream bundle for the Kyber coefficient packer.
// The slave modport is the packer; the master modport is its environment.
interface kyber_coef_packer_if;
   import kyber_pkg::*;

   logic        s_valid;
   logic        s_ready;
   coef_t       s_coef;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_last;

   modport master (
      output s_valid, s_coef, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );

   modport slave (
      input  s_valid, s_coef, s_last, m_ready,
      output s_ready, m_valid, m_data, m_last
   );

endinterface

// File: rtl/kyber_coef_packer_canon.sv
// Combinational int16 -> canonical 12-bit coefficient (caddq), with an optional
// Barrett pre-reduction when KYBER_COEF_PACKER_REDUCE_EN is defined.
module kyber_coef_canon
   import kyber_pkg::*;
(
   input  coef_t  coef_i,
   output ucoef_t ucoef_o
);

   coef_t r_w;

`ifdef KYBER_COEF_PACKER_REDUCE_EN
   logic signed [31:0] coef_ext_w;
   logic signed [31:0] prod_w;
   logic signed [31:0] t_w;

   assign coef_ext_w = {{16{coef_i[15]}}, coef_i};
   assign prod_w     = coef_ext_w * BARRETT_V + 32'sd33554432;
   assign t_w        = prod_w >>> 26;
   // Remainder is small enough that 16-bit wraparound cannot occur.
   assign r_w        = 16'(coef_ext_w - t_w * KYBER_Q);
`else
   assign r_w = coef_i;
`endif

   assign ucoef_o = r_w[15] ? 12'(r_w + coef_t'(KYBER_Q)) : r_w[11:0];

endmodule

// File: rtl/kyber_coef_packer.sv
// Packs a stream of signed coefficients into Kyber 12-bit byte encoding (3 bytes / 2 coefs).
// Optional Barrett reduction of the input: define KYBER_COEF_PACKER_REDUCE_EN.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_GET0  | waiting for first coefficient of a pair
//   ST_GET1  | waiting for second coefficient of a pair
//   ST_EMIT0 | presenting byte u0[7:0]
//   ST_EMIT1 | presenting byte {u1[3:0], u0[11:8]}
//   ST_EMIT2 | presenting byte u1[11:4] (m_last if pair ends poly)
module kyber_coef_packer
   import kyber_pkg::*;
#(
   parameter int N = KYBER_N
)
(
   input  logic               clk,
   input  logic               rst_n,
   kyber_coef_packer_if.slave bus,
   output logic               err
);

   localparam int IDX_W = (N > 2) ? $clog2(N) : 1;

   pack_state_e      state_q, state_d;
   ucoef_t           u0_q, u0_d;
   ucoef_t           u1_q, u1_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             pair_last_q, pair_last_d;
   logic             err_q, err_d;
   logic [7:0]       m_data_q, m_data_d;

   ucoef_t           u_w;
   logic             idx_end_w;
   logic             end_poly_w;
   logic             s_ready_w;
   logic             m_valid_w;

   kyber_coef_canon u_canon (
      .coef_i  (bus.s_coef),
      .ucoef_o (u_w)
   );

   assign idx_end_w  = (idx_q == IDX_W'(N - 1));
   assign end_poly_w = bus.s_last | idx_end_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_GET0;
         u0_q        <= '0;
         u1_q        <= '0;
         idx_q       <= '0;
         pair_last_q <= 1'b0;
         err_q       <= 1'b0;
         m_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         u0_q        <= u0_d;
         u1_q        <= u1_d;
         idx_q       <= idx_d;
         pair_last_q <= pair_last_d;
         err_q       <= err_d;
         m_data_q    <= m_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      u0_d        = u0_q;
      u1_d        = u1_q;
      idx_d       = idx_q;
      pair_last_d = pair_last_q;
      err_d       = err_q;
      m_data_d    = m_data_q;
      s_ready_w   = 1'b0;
      m_valid_w   = 1'b0;

      case (state_q)
         ST_GET0: begin
            s_ready_w = 1'b1;
            if (bus.s_valid) begin
               u0_d        = u_w;
               pair_last_d = end_poly_w;
               idx_d       = end_poly_w ? '0 : idx_q + IDX_W'(1);
               if (bus.s_last ^ idx_end_w) err_d = 1'b1;
               // Odd-length polynomial: close the pair with a zero partner.
               if (bus.s_last) begin
                  u1_d     = '0;
                  m_data_d = u_w[7:0];
                  state_d  = ST_EMIT0;
               end else begin
                  state_d  = ST_GET1;
               end
            end
         end
         ST_GET1: begin
            s_ready_w = 1'b1;
            if (bus.s_valid) begin
               u1_d        = u_w;
               pair_last_d = pair_last_q | end_poly_w;
               idx_d       = end_poly_w ? '0 : idx_q + IDX_W'(1);
               if (bus.s_last ^ idx_end_w) err_d = 1'b1;
               m_data_d    = u0_q[7:0];
               state_d     = ST_EMIT0;
            end
         end
         ST_EMIT0: begin
            m_valid_w = 1'b1;
            if (bus.m_ready) begin
               m_data_d = {u1_q[3:0], u0_q[11:8]};
               state_d  = ST_EMIT1;
            end
         end
         ST_EMIT1: begin
            m_valid_w = 1'b1;
            if (bus.m_ready) begin
               m_data_d = u1_q[11:4];
               state_d  = ST_EMIT2;
            end
         end
         ST_EMIT2: begin
            m_valid_w = 1'b1;
            if (bus.m_ready) begin
               m_data_d    = '0;
               pair_last_d = 1'b0;
               state_d     = ST_GET0;
            end
         end
         default: state_d = ST_GET0;
      endcase
   end

   assign bus.s_ready = s_ready_w;
   assign bus.m_valid = m_valid_w;
   assign bus.m_data  = m_data_q;
   assign bus.m_last  = (state_q == ST_EMIT2) && pair_last_q;
   assign err         = err_q;

endmodule

// File: tb/tb_kyber_coef_packer.sv
// Self-checking bench for kyber_coef_packer: directed and random polynomials against an
// arithmetic reference (mod-Q canonicalisation, 24-bit little-endian packing).
module tb_kyber_coef_packer;

   logic clk = 1'b0;
   logic rst_n;
   logic err;
   logic err2;

   int checks = 0;
   int errors = 0;

   int midx_m[2];
   bit err_m[2];

   kyber_coef_packer_if ifc ();
   kyber_coef_packer_if ifc2 ();

   kyber_coef_packer #(.N(256)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc),
      .err   (err)
   );

   kyber_coef_packer #(.N(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc2),
      .err   (err2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit srdy(input bit sel);
      return sel ? ifc2.s_ready : ifc.s_ready;
   endfunction

   function automatic bit mv(input bit sel);
      return sel ? ifc2.m_valid : ifc.m_valid;
   endfunction

   function automatic logic [7:0] md(input bit sel);
      return sel ? ifc2.m_data : ifc.m_data;
   endfunction

   function automatic bit ml(input bit sel);
      return sel ? ifc2.m_last : ifc.m_last;
   endfunction

   task automatic set_s(input bit sel, input bit v, input int c, input bit l);
      if (sel) begin
         ifc2.s_valid = v; ifc2.s_coef = 16'(c); ifc2.s_last = l;
      end else begin
         ifc.s_valid = v; ifc.s_coef = 16'(c); ifc.s_last = l;
      end
   endtask

   task automatic set_mr(input bit sel, input bit r);
      if (sel) ifc2.m_ready = r;
      else     ifc.m_ready  = r;
   endtask

   // Canonical representative in [0,Q), after the optional Barrett stage.
   function automatic int canon(input int c);
      int r;
`ifdef KYBER_COEF_PACKER_REDUCE_EN
      longint t;
      t = (longint'(20159) * longint'(c) + 64'sd33554432) >>> 26;
      r = c - int'(t) * 3329;
`else
      r = c;
`endif
      return ((r % 3329) + 3329) % 3329;
   endfunction

   function automatic int rc();
      return int'($urandom_range(6656, 0)) - 3328;
   endfunction

   // Framing reference: returns 1 when this coefficient closes a polynomial.
   function automatic bit upd(input bit sel, input bit l);
      int nn;
      bit at_end;
      nn = sel ? 2 : 256;
      at_end = (midx_m[sel] == nn - 1);
      if (l != at_end) err_m[sel] = 1'b1;
      if (l || at_end) begin
         midx_m[sel] = 0;
         return 1'b1;
      end
      midx_m[sel]++;
      return 1'b0;
   endfunction

   task automatic send(input bit sel, input int c, input bit l, input string tag);
      int cyc;
      cyc = 0;
      set_s(sel, 1'b1, c, l);
      while (!srdy(sel) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_rdy"}, 32'(srdy(sel)), 32'd1);
      @(negedge clk);
      set_s(sel, 1'b0, 0, 1'b0);
   endtask

   task automatic recv(input bit sel, input logic [7:0] ed, input bit el, input bit rnd, input string tag);
      bit held;
      bit done;
      bit r;
      logic [7:0] hd;
      held = 1'b0; done = 1'b0; hd = '0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if (held) begin
            chk({tag, "_hold_v"}, 32'(mv(sel)), 32'd1);
            chk({tag, "_hold_d"}, 32'(md(sel)), 32'(hd));
         end
         if (mv(sel)) begin
            r = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (r) begin
               chk({tag, "_d"}, 32'(md(sel)), 32'(ed));
               chk({tag, "_l"}, 32'(ml(sel)), 32'(el));
               set_mr(sel, 1'b1);
               @(negedge clk);
               set_mr(sel, 1'b0);
               done = 1'b1;
            end else begin
               held = 1'b1;
               hd   = md(sel);
               @(negedge clk);
            end
         end else begin
            @(negedge clk);
         end
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
   endtask

   task automatic pair(input bit sel, input int c0, input bit l0, input int c1, input bit l1,
                       input bit use_exp, input logic [23:0] exp_w, input bit rnd, input string tag);
      bit plast;
      int u0;
      int u1;
      logic [23:0] w;
      send(sel, c0, l0, tag);
      plast = upd(sel, l0);
      u0 = canon(c0);
      u1 = 0;
      if (!l0) begin
         send(sel, c1, l1, tag);
         plast = upd(sel, l1) | plast;
         u1 = canon(c1);
      end
      w = use_exp ? exp_w : 24'(u0 + (u1 << 12));
      recv(sel, w[7:0],   1'b0,  rnd, {tag, "_b0"});
      recv(sel, w[15:8],  1'b0,  rnd, {tag, "_b1"});
      recv(sel, w[23:16], plast, rnd, {tag, "_b2"});
   endtask

   initial begin
      int c0;
      int c1;
      logic [23:0] w;

      rst_n = 1'b0;
      set_s(1'b0, 1'b0, 0, 1'b0);
      set_s(1'b1, 1'b0, 0, 1'b0);
      set_mr(1'b0, 1'b0);
      set_mr(1'b1, 1'b0);
      midx_m = '{0, 0};
      err_m  = '{1'b0, 1'b0};
      repeat (2) @(negedge clk);
      chk("rst_s_ready", 32'(ifc.s_ready), 32'd1);
      chk("rst_m_valid", 32'(ifc.m_valid), 32'd0);
      chk("rst_m_data",  32'(ifc.m_data),  32'd0);
      chk("rst_m_last",  32'(ifc.m_last),  32'd0);
      chk("rst_err",     32'(err),         32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Two-coefficient polynomial on the N=2 instance.
      pair(1'b1, 1, 1'b0, 3328, 1'b1, 1'b1, 24'hD00001, 1'b0, "t1");
      chk("t1_err", 32'(err2), 32'(err_m[1]));

      // Negative inputs, first pair of a full polynomial.
      pair(1'b0, -1, 1'b0, -3328, 1'b0, 1'b1, 24'h001D00, 1'b0, "t2");

      // Rest of the 256-coefficient polynomial with random backpressure.
      for (int k = 0; k < 127; k++) begin
         c0 = rc();
         c1 = rc();
         pair(1'b0, c0, 1'b0, c1, (k == 126), 1'b0, '0, 1'b1, "t3");
      end
      chk("t3_err", 32'(err), 32'(err_m[0]));

`ifdef KYBER_COEF_PACKER_REDUCE_EN
      pair(1'b0, -32768, 1'b0, 32767, 1'b0, 1'b1, 24'hAF620A, 1'b0, "t4a");
      pair(1'b0, 3329, 1'b0, 0, 1'b0, 1'b1, 24'h000000, 1'b0, "t4b");
`endif

      // Early s_last on coefficient index 10.
      while (midx_m[0] < 10) pair(1'b0, rc(), 1'b0, rc(), 1'b0, 1'b0, '0, 1'b1, "t5a");
      pair(1'b0, rc(), 1'b1, 0, 1'b0, 1'b0, '0, 1'b1, "t5a_last");
      chk("t5a_err", 32'(err), 32'd1);

      // Next polynomial indexed from 0; no s_last, wraps at index 255.
      for (int k = 0; k < 128; k++) pair(1'b0, rc(), 1'b0, rc(), 1'b0, 1'b0, '0, 1'b1, "t5b");
      chk("t5b_err", 32'(err), 32'd1);

      // Odd-length polynomial: s_last on index 2.
      pair(1'b0, rc(), 1'b0, rc(), 1'b0, 1'b0, '0, 1'b1, "t5c");
      pair(1'b0, rc(), 1'b1, 0, 1'b0, 1'b0, '0, 1'b1, "t5c_odd");
      chk("t5c_err", 32'(err), 32'd1);

      // Reset while the second byte is stalled.
      c0 = rc();
      c1 = rc();
      send(1'b0, c0, 1'b0, "t6");
      void'(upd(1'b0, 1'b0));
      send(1'b0, c1, 1'b0, "t6");
      void'(upd(1'b0, 1'b0));
      w = 24'(canon(c0) + (canon(c1) << 12));
      recv(1'b0, w[7:0], 1'b0, 1'b0, "t6_b0");
      chk("t6_emit1_v", 32'(ifc.m_valid), 32'd1);
      chk("t6_emit1_d", 32'(ifc.m_data),  32'(w[15:8]));
      rst_n = 1'b0;
      #1;
      chk("t6_rst_m_valid", 32'(ifc.m_valid), 32'd0);
      chk("t6_rst_s_ready", 32'(ifc.s_ready), 32'd1);
      chk("t6_rst_err",     32'(err),         32'd0);
      chk("t6_rst_m_last",  32'(ifc.m_last),  32'd0);
      midx_m = '{0, 0};
      err_m  = '{1'b0, 1'b0};
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("t6_idle_m_valid", 32'(ifc.m_valid), 32'd0);
      end
      pair(1'b0, rc(), 1'b0, rc(), 1'b0, 1'b0, '0, 1'b1, "t6_after");
      chk("t6_after_err", 32'(err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
